mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Multicycle controller that sequences register write-back and memory access for the datapath's load/store path. It accepts one operation at a time from the main control FSM. It drives the write-data select (ALU result / memory data register / shifted-immediate), the register-file write enable, the MDR latch and the memory write strobe. Sub-word stores are handled as read-modify-write. Misaligned accesses are flagged without side effects.

## Interface
Parameters:
- MEM_WAIT, default 2: number of cycles between the address being presented and read data being valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  operation, latched at accept:
  - 000 ALU write-back
  - 001 LW, 010 LH, 011 LB
  - 100 SW, 101 SH, 110 SB
  - 111 LUI write-back
- addr_lo  in  2  effective address bits [1:0], latched at accept.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse in the final cycle of an operation.
- err  out  1  one-cycle pulse (together with done) on misaligned access.
- memto_reg  out  2  write-data select: 00 ALU result, 01 MDR, 10 shifted immediate.
- reg_write  out  1  register-file write enable.
- mdr_load  out  1  latch memory read data into the MDR.
- mem_wr  out  1  memory write strobe.
- size_sel  out  2  00 word, 01 half, 10 byte. Selects load extension during WB and store merge during WRITE.

## Operation
- States: IDLE, ADDR, WAIT, LATCH, WB, WRITE, ERR.
- All outputs are Moore-decoded from state plus the latched op/addr_lo registers. No input feeds an output combinationally.
- Accept: in IDLE with start=1, latch op and addr_lo, then branch on op:
  - ALU or LUI: go to WB.
  - SW, if aligned: go to WRITE.
  - Any other aligned load/store: go to ADDR.
  - Any misaligned access: go to ERR.
- Alignment rules:
  - LW/SW require addr_lo=00.
  - LH/SH require addr_lo[0]=0.
  - LB/SB are always aligned.
  - ALU/LUI ignore addr_lo.
- ADDR → WAIT. The wait counter is loaded with MEM_WAIT-1.
- WAIT: decrement the counter each cycle; go to LATCH in the cycle the counter reads 0. WAIT therefore lasts exactly MEM_WAIT cycles.
- LATCH: mdr_load=1. Loads then go to WB; SH/SB go to WRITE.
- WB:
  - reg_write=1 and done=1.
  - memto_reg is 00 for ALU, 01 for loads, 10 for LUI.
  - size_sel follows the load size (00 for ALU/LUI).
  - Next state is IDLE.
- WRITE: mem_wr=1, done=1, size_sel follows the store size; next state is IDLE.
- ERR: err=1, done=1; reg_write, mem_wr and mdr_load stay 0; next state is IDLE.
- In every state, any output not listed is 0, and memto_reg defaults to 00.
- A start asserted while busy is ignored and is not queued.

## Timing
- Cycle numbering: the accept edge is c0; later cycles are counted from there.
- Latency to done:
  - ALU/LUI: c1.
  - SW: c1.
  - Misaligned access: c1.
  - Loads and SH/SB: c(MEM_WAIT+3). With MEM_WAIT=2 this is c5.
- Back-to-back: a start in the done cycle is ignored. A start in the following IDLE cycle is accepted, so the minimum issue interval is 2 cycles.
- Reset, asynchronous:
  - state goes to IDLE, the wait counter and latched op/addr_lo go to 0.
  - All outputs go to 0 immediately: busy, done, err, memto_reg=00, reg_write, mdr_load, mem_wr, size_sel=00.
  - Reset during WRITE or WB kills the strobe in the same cycle. The aborted operation produces no done.
- Reset release: the first possible accept is the first rising edge with reset low.

## Test plan
- Reset mid-LW in WAIT (MEM_WAIT=2) → all outputs 0 at once; no mdr_load or done; next start op=000 → reg_write=1, memto_reg=00, done at c1.
- LW, addr_lo=00, MEM_WAIT=2 → busy c1–c5; mdr_load only at c4; c5 reg_write=1, memto_reg=01, size_sel=00, done=1; mem_wr never asserted.
- SH, addr_lo=10, MEM_WAIT=2 → mdr_load at c4; c5 mem_wr=1, size_sel=01, done=1; reg_write never asserted.
- LW with addr_lo=01, and SH with addr_lo=11 → c1 err=1, done=1; reg_write, mem_wr and mdr_load are 0 throughout.
- LUI back-to-back: start held high through c1 and c2 → done at c1 only; second accept at edge c2, second done at c3 with memto_reg=10.
- SB, addr_lo=11, MEM_WAIT=1 → WAIT lasts exactly 1 cycle, mdr_load at c3, c4 mem_wr=1, size_sel=10, done=1.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - multicycle write-back / memory access sequencer for the load/store path
module mem_access_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] memto_reg,
    output logic       reg_write,
    output logic       mdr_load,
    output logic       mem_wr,
    output logic [1:0] size_sel
);

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SH  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_LUI = 3'b111;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_WB,
        S_WRITE,
        S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] cnt_q, cnt_d;

    logic       misaligned;
    logic       is_load_q;

    // Alignment of the incoming request, evaluated on the live inputs at accept.
    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW: misaligned = (addr_lo != 2'b00);
            OP_LH, OP_SH: misaligned = addr_lo[0];
            default:      misaligned = 1'b0;
        endcase
    end

    assign is_load_q = (op_q == OP_LW) || (op_q == OP_LH) || (op_q == OP_LB);

    // State, latched request and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 2'b00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE only, count down memory latency in WAIT.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    addr_d = addr_lo;
                    if (op == OP_ALU || op == OP_LUI) begin
                        state_d = S_WB;
                    end else if (misaligned) begin
                        state_d = S_ERR;
                    end else if (op == OP_SW) begin
                        // Full-word store needs no read, so no merge cycle.
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_LATCH: begin
                // Sub-word stores continue to the merge-and-write cycle.
                state_d = is_load_q ? S_WB : S_WRITE;
            end
            S_WB:    state_d = S_IDLE;
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from state and the latched request only.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        memto_reg = 2'b00;
        reg_write = 1'b0;
        mdr_load  = 1'b0;
        mem_wr    = 1'b0;
        size_sel  = 2'b00;
        case (state_q)
            S_LATCH: mdr_load = 1'b1;
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                case (op_q)
                    OP_LW:   begin memto_reg = 2'b01; size_sel = 2'b00; end
                    OP_LH:   begin memto_reg = 2'b01; size_sel = 2'b01; end
                    OP_LB:   begin memto_reg = 2'b01; size_sel = 2'b10; end
                    OP_LUI:  memto_reg = 2'b10;
                    default: memto_reg = 2'b00;
                endcase
            end
            S_WRITE: begin
                mem_wr = 1'b1;
                done   = 1'b1;
                case (op_q)
                    OP_SH:   size_sel = 2'b01;
                    OP_SB:   size_sel = 2'b10;
                    default: size_sel = 2'b00;
                endcase
            end
            S_ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [1:0] addr_lo;

    logic       busy2, done2, err2, rw2, ml2, mw2;
    logic [1:0] mt2, sz2;
    logic       busy1, done1, err1, rw1, ml1, mw1;
    logic [1:0] mt1, sz1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.MEM_WAIT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_lo(addr_lo),
        .busy(busy2), .done(done2), .err(err2), .memto_reg(mt2), .reg_write(rw2),
        .mdr_load(ml2), .mem_wr(mw2), .size_sel(sz2)
    );

    mem_access_sequencer #(.MEM_WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_lo(addr_lo),
        .busy(busy1), .done(done1), .err(err1), .memto_reg(mt1), .reg_write(rw1),
        .mdr_load(ml1), .mem_wr(mw1), .size_sel(sz1)
    );

    // Observed vector layout: {busy, done, err, memto_reg[1:0], reg_write, mdr_load, mem_wr, size_sel[1:0]}
    wire [9:0] o2 = {busy2, done2, err2, mt2, rw2, ml2, mw2, sz2};
    wire [9:0] o1 = {busy1, done1, err1, mt1, rw1, ml1, mw1, sz1};

    function automatic logic [9:0] v(input logic b, input logic d, input logic e,
                                     input logic [1:0] mt, input logic rw, input logic ml,
                                     input logic mw, input logic [1:0] sz);
        return {b, d, e, mt, rw, ml, mw, sz};
    endfunction

    logic [9:0] ev [1:8];

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Present a request on the next falling edge; returns in cycle c1 with start dropped.
    task automatic issue(input logic [2:0] o, input logic [1:0] a);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        addr_lo = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compare cycles c1..cn of one instance against ev[]; caller is already in c1.
    task automatic run(input string tag, input int n, input bit use1);
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("%s_c%0d", tag, k), use1 ? o1 : o2, ev[k]);
        end
    endtask

    task automatic idle_both(input string tag);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_idle2"}, o2, 10'd0);
        chk({tag, "_idle1"}, o1, 10'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; addr_lo = 2'b00;
        #1;
        chk("rst_async2", o2, 10'd0);
        chk("rst_async1", o1, 10'd0);
        @(negedge clk); @(negedge clk);
        chk("rst_held2", o2, 10'd0);
        reset = 1'b0;

        // LW aligned, MEM_WAIT=2
        ev[1] = v(1,0,0,2'b00,0,0,0,2'b00);
        ev[2] = v(1,0,0,2'b00,0,0,0,2'b00);
        ev[3] = v(1,0,0,2'b00,0,0,0,2'b00);
        ev[4] = v(1,0,0,2'b00,0,1,0,2'b00);
        ev[5] = v(1,1,0,2'b01,1,0,0,2'b00);
        ev[6] = 10'd0;
        issue(3'b001, 2'b00);
        run("lw", 6, 1'b0);

        // LB at odd address, MEM_WAIT=2: byte extension select in WB
        ev[4] = v(1,0,0,2'b00,0,1,0,2'b00);
        ev[5] = v(1,1,0,2'b01,1,0,0,2'b10);
        issue(3'b011, 2'b11);
        run("lb", 6, 1'b0);

        // SH aligned to halfword, MEM_WAIT=2: read-modify-write
        ev[5] = v(1,1,0,2'b00,0,0,1,2'b01);
        issue(3'b101, 2'b10);
        run("sh", 6, 1'b0);

        // SW aligned goes straight to WRITE
        ev[1] = v(1,1,0,2'b00,0,0,1,2'b00);
        ev[2] = 10'd0;
        issue(3'b100, 2'b00);
        run("sw", 2, 1'b0);

        // Misaligned LW and SH: error pulse only
        ev[1] = v(1,1,1,2'b00,0,0,0,2'b00);
        ev[2] = 10'd0;
        issue(3'b001, 2'b01);
        run("lw_mis", 2, 1'b0);
        issue(3'b101, 2'b11);
        run("sh_mis", 2, 1'b0);
        issue(3'b101, 2'b11);
        run("sh_mis_w1", 2, 1'b1);

        // LUI back-to-back: start held through edges c0, c1, c2
        @(negedge clk);
        start = 1'b1; op = 3'b111; addr_lo = 2'b01;
        @(negedge clk);
        chk("lui_c1", o2, v(1,1,0,2'b10,1,0,0,2'b00));
        @(negedge clk);
        chk("lui_c2", o2, 10'd0);
        @(negedge clk);
        start = 1'b0;
        chk("lui_c3", o2, v(1,1,0,2'b10,1,0,0,2'b00));
        @(negedge clk);
        chk("lui_c4", o2, 10'd0);

        // SB at addr 11 on the MEM_WAIT=1 instance
        ev[1] = v(1,0,0,2'b00,0,0,0,2'b00);
        ev[2] = v(1,0,0,2'b00,0,0,0,2'b00);
        ev[3] = v(1,0,0,2'b00,0,1,0,2'b00);
        ev[4] = v(1,1,0,2'b00,0,0,1,2'b10);
        ev[5] = 10'd0;
        issue(3'b110, 2'b11);
        run("sb_w1", 5, 1'b1);
        idle_both("sb");

        // Reset during WRITE drops the strobe immediately
        issue(3'b100, 2'b00);
        chk("sw_rst_pre", o2, v(1,1,0,2'b00,0,0,1,2'b00));
        #1 reset = 1'b1;
        #1 chk("sw_rst_now", o2, 10'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-LW while in WAIT
        issue(3'b001, 2'b00);
        @(negedge clk);
        chk("lwr_wait", o2, v(1,0,0,2'b00,0,0,0,2'b00));
        #2 reset = 1'b1;
        #1 chk("lwr_async", o2, 10'd0);
        @(negedge clk);
        chk("lwr_held_a", o2, 10'd0);
        @(negedge clk);
        chk("lwr_held_b", o2, 10'd0);
        reset = 1'b0; start = 1'b1; op = 3'b000; addr_lo = 2'b10;
        @(negedge clk);
        start = 1'b0;
        chk("alu_c1", o2, v(1,1,0,2'b00,1,0,0,2'b00));
        @(negedge clk);
        chk("alu_c2", o2, 10'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
